// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable single-port RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_e;

    // True when addr names a real word; DEPTH need not be a power of two.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Zero-fill sequencer: walks cnt across the whole array after reset or on a
// clear request, holding busy high for exactly DEPTH edges.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_e        state_reg;
    ram_state_e        state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A clear request while already clearing is ignored: the pass never restarts.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            CLEAR: begin
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt_reg;

endmodule

// File: rtl/ram_clearable.sv
// Parametrised single-port RAM with a hardware zero-fill engine, busy and
// dropped-write indications, and a selectable combinational/registered read.
module ram_clearable
    import ram_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int DEPTH   = 512,
    parameter  int REG_OUT = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ld,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              busy,
    output logic              drop
);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              addr_in_range;
    logic              user_we;
    logic              read_gate;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              drop_reg;
    logic              drop_next;

    ram_clear_seq #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    assign addr_in_range = addr_ok(32'(addr), DEPTH);
    // A clear request wins over a simultaneous user write.
    assign user_we       = ld && !busy && !clr && addr_in_range;
    assign read_gate     = busy || !addr_in_range;

    always_comb begin
        wr_en   = user_we;
        wr_addr = addr;
        wr_data = in;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign drop_next = ld && (busy || clr || !addr_in_range);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_reg <= 1'b0;
        end else begin
            drop_reg <= drop_next;
        end
    end

    assign drop = drop_reg;

    generate
        if (REG_OUT != 0) begin : g_reg_read
            logic [WIDTH-1:0] out_reg;

            // Read-first: a same-edge write to addr is seen one edge later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= read_gate ? '0 : mem[addr];
                end
            end

            // Also gate on the live busy so a freshly started clear hides stale data.
            assign out = busy ? '0 : out_reg;
        end else begin : g_comb_read
            assign out = read_gate ? '0 : mem[addr];
        end
    endgenerate

endmodule

// File: doc/ram_clearable.md
# ram_clearable

Parametrised successor to the fixed 512×16 load/address RAM: single-port, configurable width and depth, with selectable combinational or registered read. Adds a hardware clear engine that zero-fills the array after reset or on request, plus busy and dropped-write indications. It replaces the fixed-size RAM blocks in the data-memory path, and the CPU stalls on `busy`.

## Interface
- `WIDTH`, 16: data word width in bits.
- `DEPTH`, 512: number of words, ≥2; need not be a power of two.
- `REG_OUT`, 0: 0 = combinational read (legacy Hack behaviour), 1 = registered read with one-cycle latency.
- `ADDR_W`, `$clog2(DEPTH)`: address width; derived, not overridden.

- `clk`  in  1: the single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in`  in  WIDTH: write data.
- `addr`  in  ADDR_W: read/write address.
- `ld`  in  1: write `in` to `mem[addr]` at the rising edge.
- `clr`  in  1: request a full zero-fill; level-sampled.
- `out`  out  WIDTH: read data.
- `busy`  out  1: clear in progress; writes are ignored.
- `drop`  out  1: one-cycle pulse when a requested write was discarded.

## Operation
- **States:** CLEAR and IDLE, with counter `cnt` of width ADDR_W.
- **Reset:** asserting `rst_n` low forces CLEAR, `cnt=0`, `busy=1`, `drop=0`, and the registered `out`=0. Array contents are not reset directly; the clear pass zeroes them.
- **CLEAR:** each edge writes `mem[cnt]=0` and increments `cnt`. On the edge where `cnt==DEPTH-1`, the block moves to IDLE and `busy` goes to 0.
- **IDLE, `clr`=1:** next edge enters CLEAR with `cnt=0` and `busy=1`. If `ld` is also asserted, the write is discarded and `drop` pulses; `clr` has priority.
- **IDLE, `ld`=1, `clr`=0:**
  - If `addr<DEPTH`, write `mem[addr]=in`.
  - If `addr>=DEPTH`, no write and `drop` pulses.
- **`ld` while `busy`:** discarded; `drop` pulses on that edge.
- **`clr` while `busy`:** ignored. The current pass continues and does not restart.
- **Reset mid-clear:** the pass restarts from `cnt=0` after release.
- **Read, `REG_OUT=0`:** `out = mem[addr]` combinationally.
- **Read, `REG_OUT=1`:** `out` is registered from `mem[addr]` at each edge. This is read-first: a same-address write returns the old word, and the new word appears one edge later.
- **Read in both modes:**
  - `addr>=DEPTH` reads 0.
  - While `busy`=1, `out` reads 0.

## Timing
- **Reset values:**
  - `busy`=1 while `rst_n`=0.
  - `drop`=0.
  - `out`=0 (registered mode), and 0 via the busy gate in combinational mode.
- **After `rst_n` rises:** `busy` stays high for exactly DEPTH rising edges and falls on edge DEPTH.
- **`clr` sampled on edge k:** `busy`=1 from edge k, and `busy`=0 after edge k+DEPTH.
- **Write on edge k:**
  - `REG_OUT=0`: data is visible at `out` immediately after edge k.
  - `REG_OUT=1`: data is visible at `out` after edge k+1.
- **`drop`:** registered, asserted for the single cycle following the offending edge.
- **First usable write:** the edge at which `busy` is sampled 0.

## Structure
- **Package `ram_pkg`:**
  - `ram_state_e` enum {CLEAR, IDLE}.
  - Function `addr_ok(addr, depth)` for the range check.
- **Sub-module `ram_clear_seq`:** FSM plus `cnt`. Outputs `busy`, `clr_we`, and `clr_addr`; inputs `clk`, `rst_n`, `clr`.
- **Top `ram_clearable`:**
  - Holds the array and the write-port mux: clear engine when busy, else user.
  - Holds the read path, generated on `REG_OUT`, and the `drop` register.

## Test plan
All scenarios use WIDTH=16 and DEPTH=512 unless stated.
1. **Reset-clear:** hold `rst_n`=0 for 3 cycles, then release → `busy`=1 for exactly 512 edges, then 0. Reads of addresses 0, 255 and 511 return 0x0000.
2. **Write/read (`REG_OUT=0`):** write 0xBEEF at 0x1A3 → `out`=0xBEEF in the same cycle after the edge. Write 0x1234 at 0x000 leaves 0x1A3 unchanged.
3. **Registered read-first (`REG_OUT=1`):**
   - Preload 0x1111 at 5.
   - Write 0x2222 at 5 with `addr`=5 held → `out`=0x1111 after that edge, then 0x2222 after the next.
4. **Clear request with collision:**
   - Fill 0..511 with `~addr`.
   - Pulse `clr` together with `ld` (0xAAAA at 7) → `drop` pulses once and `busy` stays high 512 cycles.
   - Afterwards all reads are 0, including address 7.
5. **Writes and `clr` during busy:** issue `ld` at cycle 100 of the clear → `drop`=1 for one cycle, and the location reads 0 after clear. A `clr` pulse at cycle 200 does not extend `busy` beyond 512.
6. **DEPTH=300 boundaries:**
   - Write to `addr`=300 → `drop`=1, and the read returns 0.
   - Reset asserted at clear cycle 150 → after release, `busy` lasts exactly 300 cycles.
